wupr_refresh_scheduler: RTL

//  Sequences DRAM refresh for the write-upper-peak-refresh (WUPR) scheme.
//  - Generates one refresh obligation per tREFI interval; keeps a backlog of postponed refreshes.
//  - Asks the segment-peak tracker whether the current row needs a real REF or can be skipped as a dummy refresh.
//  - Issues real REFs to the command arbiter with a req/gnt handshake.
//  - Sits between the WUPR segment-peak tracker and the DRAM command arbiter.

---
 rtl/wupr_pkg.sv | 19 +
 rtl/wupr_interval_timer.sv | 30 +++
 rtl/wupr_refresh_scheduler.sv | 121 ++++++++++++
 3 files changed

// File: rtl/wupr_pkg.sv
// Shared state encoding, default timing and row type for the WUPR refresh scheduler.
package wupr_pkg;

  localparam int DEF_ROW_WIDTH    = 16;
  localparam int DEF_T_REFI       = 7800;
  localparam int DEF_T_RFC        = 350;
  localparam int DEF_MAX_POSTPONE = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_DECIDE   = 3'd2,
    ST_REQ      = 3'd3,
    ST_WAIT_RFC = 3'd4
  } wupr_ref_state_e;

  typedef logic [DEF_ROW_WIDTH-1:0] row_t;

endpackage

// File: rtl/wupr_interval_timer.sv
// Reloadable down-counter: tick is high while the count sits at 0; the count reloads
// to PERIOD-1 on load or when it expires while enabled.
module wupr_interval_timer #(
  parameter int PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  output logic tick
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] RELOAD = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (load || (en && cnt == '0)) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/wupr_refresh_scheduler.sv
// WUPR refresh scheduler: tREFI obligations, postponement backlog, skip query, REF req/gnt.
// Optional WUPR_SKIP_STATS_EN adds skip_cnt / issue_cnt statistics outputs.
module wupr_refresh_scheduler
  import wupr_pkg::*;
#(
  parameter int ROW_WIDTH    = DEF_ROW_WIDTH,
  parameter int T_REFI       = DEF_T_REFI,
  parameter int T_RFC        = DEF_T_RFC,
  parameter int MAX_POSTPONE = DEF_MAX_POSTPONE,
  parameter int PEND_W       = $clog2(MAX_POSTPONE + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 chk_valid,
  output logic [ROW_WIDTH-1:0] chk_row,
  input  logic                 chk_skip,
  output logic                 ref_req,
  output logic [ROW_WIDTH-1:0] ref_row,
  input  logic                 ref_gnt,
  output logic                 ref_urgent,
  output logic                 busy,
  output logic [PEND_W-1:0]    pending,
  output logic                 window_done,
  output logic                 err_overflow
`ifdef WUPR_SKIP_STATS_EN
  ,
  output logic [31:0]          skip_cnt,
  output logic [31:0]          issue_cnt
`endif
);

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_POSTPONE);

  wupr_ref_state_e      state, state_nxt;
  logic [ROW_WIDTH-1:0] row_ptr;
  logic [PEND_W-1:0]    pend_q, pend_nxt;
  logic                 refi_tick, rfc_done;
  logic                 skip_done, gnt_done, completion, err_set;

  // Handshake: ref_req is high for every cycle in REQ; a cycle with ref_req=1 and
  // ref_gnt=1 is the transfer, and ref_req drops in the following cycle.
  assign skip_done  = (state == ST_DECIDE) && chk_skip;
  assign gnt_done   = (state == ST_REQ) && ref_gnt;
  assign completion = skip_done || gnt_done;

  wupr_interval_timer #(.PERIOD(T_REFI)) u_refi_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .load  (1'b0),
    .tick  (refi_tick)
  );

  wupr_interval_timer #(.PERIOD(T_RFC)) u_rfc_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_WAIT_RFC),
    .load  (gnt_done),
    .tick  (rfc_done)
  );

  // A tick in IDLE starts the query at once so tick-to-ref_req is three cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (pend_q != '0 || refi_tick) state_nxt = ST_CHECK;
      ST_CHECK:    state_nxt = ST_DECIDE;
      ST_DECIDE:   state_nxt = chk_skip ? ST_IDLE : ST_REQ;
      ST_REQ:      if (ref_gnt) state_nxt = ST_WAIT_RFC;
      ST_WAIT_RFC: if (rfc_done) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pend_nxt = pend_q;
    err_set  = 1'b0;
    if (refi_tick && !completion) begin
      if (pend_q == PEND_MAX) err_set = 1'b1;
      else                    pend_nxt = pend_q + PEND_W'(1);
    end else if (!refi_tick && completion) begin
      pend_nxt = pend_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      row_ptr      <= '0;
      pend_q       <= '0;
      err_overflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend_q <= pend_nxt;
      if (completion) row_ptr <= row_ptr + ROW_WIDTH'(1);
      if (err_set) err_overflow <= 1'b1;
    end
  end

  assign chk_valid   = (state == ST_CHECK);
  assign chk_row     = row_ptr;
  assign ref_req     = (state == ST_REQ);
  assign ref_row     = row_ptr;
  assign busy        = (state == ST_WAIT_RFC);
  assign pending     = pend_q;
  assign ref_urgent  = (pend_q >= PEND_MAX);
  assign window_done = completion && (row_ptr == '1);

`ifdef WUPR_SKIP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt  <= '0;
      issue_cnt <= '0;
    end else begin
      if (skip_done) skip_cnt  <= skip_cnt + 32'd1;
      if (gnt_done)  issue_cnt <= issue_cnt + 32'd1;
    end
  end
`endif

endmodule
